rx_sram_writer: RTL and testbench

Downstream stage of the receive unit. It drains received words (8 data bits plus parity) by pulsing `receive` and checks the parity bit and the OE/BE/FE error flags. Clean bytes are written sequentially into the on-chip SRAM; bad words are dropped and counted. It is the bridge between the UART receive path and the SRAM write port, on the baud clock domain.

---
 rtl/uart_sram_pkg.sv | 28 ++
 rtl/rx_word_check.sv | 25 ++
 rtl/rx_sram_writer.sv | 128 ++++++++++++
 tb/tb_rx_sram_writer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sram_pkg.sv
// Shared definitions for the UART receive to SRAM write path:
// FSM encoding, error-flag bit positions and parity modes.
package uart_sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    localparam int ERR_PE = 3;
    localparam int ERR_OE = 2;
    localparam int ERR_BE = 1;
    localparam int ERR_FE = 0;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    function automatic logic parity_error(
        input logic [8:0] word,
        input bit         odd
    );
        return (^word) != odd;
    endfunction

endpackage

// File: rtl/rx_word_check.sv
// Qualifies one received word: parity plus the receiver's
// overrun/break/framing flags, folded into a cause vector.
module rx_word_check
    import uart_sram_pkg::*;
#(
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic [8:0] rx_data,
    input  logic       oe,
    input  logic       be,
    input  logic       fe,
    output logic       good,
    output logic [3:0] cause
);

    always_comb begin
        cause         = '0;
        cause[ERR_PE] = parity_error(rx_data, PARITY_ODD);
        cause[ERR_OE] = oe;
        cause[ERR_BE] = be;
        cause[ERR_FE] = fe;
        good          = ~|cause;
    end

endmodule

// File: rtl/rx_sram_writer.sv
// Drains the UART receive FIFO one word at a time and writes clean
// bytes sequentially into SRAM; bad words are dropped and counted.
module rx_sram_writer
    import uart_sram_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 2,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic              baud_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              rx_empty,
    input  logic [8:0]        rx_data,
    input  logic              OE,
    input  logic              BE,
    input  logic              FE,
    output logic              receive,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    output logic              full,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        err_count,
    output logic [3:0]        err_flags
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic [7:0]         hold_data;
    logic               good;
    logic [3:0]         cause;
    logic               sample;
    logic               last;
    logic [ADDR_W-1:0]  addr_inc;

    rx_word_check #(
        .PARITY_ODD(PARITY_ODD)
    ) u_check (
        .rx_data(rx_data),
        .oe     (OE),
        .be     (BE),
        .fe     (FE),
        .good   (good),
        .cause  (cause)
    );

    assign sample = (state == S_WAIT) && (wait_cnt == CNT_W'(1));
    assign last   = (sram_addr == ADDR_W'(DEPTH - 1));

    // Saturate rather than wrap when DEPTH fills the whole address space.
    assign addr_inc = (sram_addr == {ADDR_W{1'b1}}) ? sram_addr
                                                    : sram_addr + 1'b1;

    always_comb begin
        state_next = state;
        receive    = 1'b0;
        sram_we    = 1'b0;
        full       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (en && !rx_empty) state_next = S_REQ;
            end
            S_REQ: begin
                receive    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (sample) state_next = good ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                sram_we    = 1'b1;
                state_next = last ? S_FULL : S_IDLE;
            end
            S_FULL: begin
                full = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        if (clr) state_next = S_IDLE;
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            hold_data  <= '0;
            sram_addr  <= '0;
            word_count <= '0;
            err_count  <= '0;
            err_flags  <= '0;
        end else begin
            state <= state_next;
            if (clr) begin
                wait_cnt   <= '0;
                sram_addr  <= '0;
                word_count <= '0;
                err_count  <= '0;
                err_flags  <= '0;
            end else begin
                if (state == S_REQ) begin
                    wait_cnt <= CNT_W'(RD_LAT);
                end else if (state == S_WAIT) begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
                if (sample) begin
                    hold_data <= rx_data[7:0];
                    if (!good) begin
                        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
                        err_flags <= err_flags | cause;
                    end
                end
                if (state == S_WRITE) begin
                    sram_addr  <= addr_inc;
                    word_count <= word_count + 1'b1;
                end
            end
        end
    end

    assign sram_wdata = hold_data;

endmodule

// File: tb/tb_rx_sram_writer.sv
// Directed bench for rx_sram_writer: default instance plus a DEPTH=4
// instance sharing the receive-side inputs, each with its own enable.
module tb_rx_sram_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a;
    logic       en_b;
    logic       clr;
    logic       rx_empty;
    logic [8:0] rx_data;
    logic       oe;
    logic       be;
    logic       fe;

    logic       rcv_a, we_a, full_a;
    logic [7:0] addr_a, wdata_a, ec_a;
    logic [8:0] wc_a;
    logic [3:0] ef_a;

    logic       rcv_b, we_b, full_b;
    logic [7:0] addr_b, wdata_b, ec_b;
    logic [8:0] wc_b;
    logic [3:0] ef_b;

    int         errors = 0;
    int         checks = 0;

    int         n_rcv;
    logic [5:0] we_mask;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    rx_sram_writer dut_a (
        .baud_clk  (clk),
        .rst       (rst),
        .en        (en_a),
        .clr       (clr),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .OE        (oe),
        .BE        (be),
        .FE        (fe),
        .receive   (rcv_a),
        .sram_we   (we_a),
        .sram_addr (addr_a),
        .sram_wdata(wdata_a),
        .full      (full_a),
        .word_count(wc_a),
        .err_count (ec_a),
        .err_flags (ef_a)
    );

    rx_sram_writer #(
        .DEPTH(4)
    ) dut_b (
        .baud_clk  (clk),
        .rst       (rst),
        .en        (en_b),
        .clr       (clr),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .OE        (oe),
        .BE        (be),
        .FE        (fe),
        .receive   (rcv_b),
        .sram_we   (we_b),
        .sram_addr (addr_b),
        .sram_wdata(wdata_b),
        .full      (full_b),
        .word_count(wc_b),
        .err_count (ec_b),
        .err_flags (ef_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Offers one word to dut_a and records what it did over 5 cycles.
    task automatic run_word(input logic [8:0] d, input logic o,
                            input logic b, input logic f);
        rx_data  = d;
        oe       = o;
        be       = b;
        fe       = f;
        rx_empty = 1'b0;
        n_rcv    = 0;
        we_mask  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) rx_empty = 1'b1;
            if (rcv_a) n_rcv++;
            if (we_a) begin
                we_mask[i] = 1'b1;
                wr_addr    = addr_a;
                wr_data    = wdata_a;
            end
        end
        oe = 1'b0;
        be = 1'b0;
        fe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; clr = 1'b0;
        rx_empty = 1'b1; rx_data = '0; oe = 1'b0; be = 1'b0; fe = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({rcv_a, we_a, full_a, addr_a, wdata_a, wc_a, ec_a, ef_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got rcv=%b we=%b full=%b addr=%h wd=%h wc=%0d ec=%0d ef=%b want all 0",
                     rcv_a, we_a, full_a, addr_a, wdata_a, wc_a, ec_a, ef_a);
        end
        checks++;
        if ({rcv_b, we_b, full_b, addr_b, wdata_b, wc_b, ec_b, ef_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got rcv=%b we=%b full=%b addr=%h wd=%h wc=%0d ec=%0d ef=%b want all 0",
                     rcv_b, we_b, full_b, addr_b, wdata_b, wc_b, ec_b, ef_b);
        end
    endtask

    task automatic test_single_word();
        en_a = 1'b1;
        run_word(9'h0A5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (n_rcv !== 1) begin
            errors++; $display("FAIL single_rcv: got %0d want 1", n_rcv);
        end
        checks++;
        if (we_mask !== 6'b010000) begin
            errors++; $display("FAIL single_we_timing: got %b want 010000", we_mask);
        end
        checks++;
        if (wr_addr !== 8'h00 || wr_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_write: got addr=%h data=%h want 00/A5", wr_addr, wr_data);
        end
        checks++;
        if (wc_a !== 9'd1 || addr_a !== 8'd1) begin
            errors++;
            $display("FAIL single_count: got wc=%0d addr=%0d want 1/1", wc_a, addr_a);
        end
    endtask

    task automatic test_parity_error();
        do_clr();
        checks++;
        if (wc_a !== 9'd0 || addr_a !== 8'd0) begin
            errors++;
            $display("FAIL clr_counts: got wc=%0d addr=%0d want 0/0", wc_a, addr_a);
        end
        run_word(9'h1A5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (we_mask !== 6'b0 || n_rcv !== 1) begin
            errors++;
            $display("FAIL parity_we: got we=%b rcv=%0d want 000000/1", we_mask, n_rcv);
        end
        checks++;
        if (ec_a !== 8'd1 || ef_a !== 4'b1000) begin
            errors++;
            $display("FAIL parity_err: got ec=%0d ef=%b want 1/1000", ec_a, ef_a);
        end
        checks++;
        if (addr_a !== 8'd0 || wc_a !== 9'd0) begin
            errors++;
            $display("FAIL parity_addr: got addr=%0d wc=%0d want 0/0", addr_a, wc_a);
        end
    endtask

    task automatic test_mixed_errors();
        do_clr();
        run_word(9'h0A5, 1'b0, 1'b0, 1'b1);
        run_word(9'h0A5, 1'b0, 1'b1, 1'b0);
        run_word(9'h03C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ef_a !== 4'b0011 || ec_a !== 8'd2) begin
            errors++;
            $display("FAIL mixed_err: got ef=%b ec=%0d want 0011/2", ef_a, ec_a);
        end
        checks++;
        if (we_mask !== 6'b010000 || wr_addr !== 8'd0 || wr_data !== 8'h3C) begin
            errors++;
            $display("FAIL mixed_write: got we=%b addr=%h data=%h want 010000/00/3C",
                     we_mask, wr_addr, wr_data);
        end
        checks++;
        if (wc_a !== 9'd1) begin
            errors++; $display("FAIL mixed_count: got %0d want 1", wc_a);
        end
    endtask

    task automatic test_fill_full();
        int         we_cyc[8];
        logic [7:0] we_ad[8];
        logic [7:0] we_dt[8];
        int         nw;
        int         nr;
        int         first_addr;
        logic [7:0] d;
        en_a = 1'b0;
        do_clr();
        en_b = 1'b1;
        d = 8'h10;
        rx_data = {^d, d};
        rx_empty = 1'b0;
        nw = 0;
        nr = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rcv_b) nr++;
            if (we_b) begin
                if (nw < 8) begin
                    we_cyc[nw] = c;
                    we_ad[nw]  = addr_b;
                    we_dt[nw]  = wdata_b;
                end
                nw++;
                d = 8'h10 + 8'(nw);
                rx_data = {^d, d};
            end
        end
        checks++;
        if (nr !== 4 || nw !== 4) begin
            errors++; $display("FAIL fill_counts: got rcv=%0d we=%0d want 4/4", nr, nw);
        end
        for (int i = 0; i < 4 && i < nw; i++) begin
            checks++;
            if (we_ad[i] !== 8'(i) || we_dt[i] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL fill_write%0d: got addr=%h data=%h want %h/%h",
                         i, we_ad[i], we_dt[i], 8'(i), 8'h10 + 8'(i));
            end
            if (i > 0) begin
                checks++;
                if (we_cyc[i] - we_cyc[i-1] !== 5) begin
                    errors++;
                    $display("FAIL fill_spacing%0d: got %0d want 5", i, we_cyc[i] - we_cyc[i-1]);
                end
            end
        end
        checks++;
        if (full_b !== 1'b1 || wc_b !== 9'd4) begin
            errors++; $display("FAIL fill_full: got full=%b wc=%0d want 1/4", full_b, wc_b);
        end
        do_clr();
        checks++;
        if (full_b !== 1'b0 || wc_b !== 9'd0 || rcv_b !== 1'b0 || we_b !== 1'b0) begin
            errors++;
            $display("FAIL fill_clr: got full=%b wc=%0d rcv=%b we=%b want 0/0/0/0",
                     full_b, wc_b, rcv_b, we_b);
        end
        first_addr = -1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) rx_empty = 1'b1;
            if (we_b && first_addr < 0) first_addr = int'(addr_b);
        end
        checks++;
        if (first_addr !== 0) begin
            errors++; $display("FAIL fill_after_clr: got addr=%0d want 0", first_addr);
        end
        en_b = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic act;
        en_a = 1'b1;
        do_clr();
        run_word(9'h1A5, 1'b0, 1'b0, 1'b0);
        run_word(9'h0A5, 1'b0, 1'b0, 1'b0);
        rx_data  = 9'h0A5;
        rx_empty = 1'b0;
        tick();
        rx_empty = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rcv_a, we_a, full_a, addr_a, wc_a, ec_a, ef_a} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got rcv=%b we=%b full=%b addr=%0d wc=%0d ec=%0d ef=%b want all 0",
                     rcv_a, we_a, full_a, addr_a, wc_a, ec_a, ef_a);
        end
        act = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 2) rst = 1'b0;
            if (rcv_a || we_a) act = 1'b1;
        end
        checks++;
        if (act !== 1'b0 || wc_a !== 9'd0) begin
            errors++; $display("FAIL rst_after: got act=%b wc=%0d want 0/0", act, wc_a);
        end
    endtask

    task automatic test_clr_write();
        logic       we_seen;
        logic [7:0] ad_seen;
        run_word(9'h0A5, 1'b0, 1'b0, 1'b0);
        rx_data  = 9'h03C;
        rx_empty = 1'b0;
        tick();
        rx_empty = 1'b1;
        tick();
        tick();
        tick();
        we_seen = we_a;
        ad_seen = addr_a;
        clr = 1'b1;
        checks++;
        if (we_seen !== 1'b1 || ad_seen !== 8'd1) begin
            errors++;
            $display("FAIL clr_write_we: got we=%b addr=%0d want 1/1", we_seen, ad_seen);
        end
        tick();
        clr = 1'b0;
        checks++;
        if (we_a !== 1'b0 || rcv_a !== 1'b0 || addr_a !== 8'd0 || wc_a !== 9'd0) begin
            errors++;
            $display("FAIL clr_write_after: got we=%b rcv=%b addr=%0d wc=%0d want 0/0/0/0",
                     we_a, rcv_a, addr_a, wc_a);
        end
    endtask

    task automatic test_saturation();
        int   nr;
        logic any_we;
        logic [7:0] ec_at_255;
        do_clr();
        rx_data  = 9'h1A5;
        rx_empty = 1'b0;
        nr = 0;
        any_we = 1'b0;
        ec_at_255 = '0;
        for (int c = 0; c < 2000 && nr < 300; c++) begin
            tick();
            if (rcv_a) begin
                nr++;
                if (nr == 255) ec_at_255 = ec_a;
            end
            if (we_a) any_we = 1'b1;
        end
        rx_empty = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (we_a) any_we = 1'b1;
        end
        checks++;
        if (nr !== 300) begin
            errors++; $display("FAIL sat_timeout: got %0d receives want 300", nr);
        end
        checks++;
        if (ec_at_255 !== 8'd254) begin
            errors++; $display("FAIL sat_mid: got %0d want 254", ec_at_255);
        end
        checks++;
        if (ec_a !== 8'd255 || ef_a !== 4'b1000 || any_we !== 1'b0) begin
            errors++;
            $display("FAIL sat_final: got ec=%0d ef=%b we=%b want 255/1000/0", ec_a, ef_a, any_we);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_parity_error();
        test_mixed_errors();
        test_fill_full();
        test_reset_mid();
        test_clr_write();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
